// File: rtl/hqm_sbemst_arb_pkg.sv
// Shared types and constants for the sideband master egress arbiter.
// No logic; types and constants only.
// Not applicable.
package hqm_sbemst_arb_pkg;

  // Arbiter FSM: idle (arbitrating) or owning the egress for one message
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PC_MSG = 2'd1,
    NP_MSG = 2'd2
  } arb_state_t;

  // Class encoding, also used for the last_grant flop and mst_np
  localparam logic CLS_PC = 1'b0;
  localparam logic CLS_NP = 1'b1;

  localparam int DEF_INTERNALPLDBIT = 31;
  localparam int DEF_MAXCRD         = 4;

endpackage

// File: rtl/hqm_sbemst_crdcnt.sv
// Per-class message credit counter: +1 on cup, -1 on consume, sticky overflow.
// Count updates on the clock edge after cup/consume.
// Consume is only issued while nonzero; a cup at MAXCRD without consume is dropped and flagged.
module hqm_sbemst_crdcnt
  import hqm_sbemst_arb_pkg::*;
#(
  parameter int MAXCRD = DEF_MAXCRD,
  localparam int CRDW  = $clog2(MAXCRD+1)
) (
  input  logic            agent_clk,
  input  logic            agent_rst_b,
  input  logic            cup,
  input  logic            consume,
  output logic [CRDW-1:0] count,
  output logic            nonzero,
  output logic            ovf
);

  logic at_max;

  assign at_max  = (count == CRDW'(MAXCRD));
  assign nonzero = (count != '0);

  // Credit count; simultaneous cup and consume cancel out
  always_ff @(posedge agent_clk or negedge agent_rst_b) begin
    if (!agent_rst_b) begin
      count <= '0;
    end else if (cup && !consume) begin
      if (!at_max) count <= count + CRDW'(1);
    end else if (consume && !cup) begin
      count <= count - CRDW'(1);
    end
  end

  // Sticky overflow: fabric returned a credit we have no room for
  always_ff @(posedge agent_clk or negedge agent_rst_b) begin
    if (!agent_rst_b) begin
      ovf <= 1'b0;
    end else if (cup && !consume && at_max) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/hqm_sbemst_arb.sv
// Message-atomic PC/NP egress arbiter with per-class credits and a registered egress flit.
// Grant at n, sel at n+1, first flit on mst_put at n+2; 1 flit/cycle within a message.
// trdy depends only on state, mst_put and mst_ready; egress flit holds while mst_ready is low.
module hqm_sbemst_arb
  import hqm_sbemst_arb_pkg::*;
#(
  parameter int INTERNALPLDBIT = DEF_INTERNALPLDBIT,
  parameter int MAXCRD         = DEF_MAXCRD,
  localparam int CRDW          = $clog2(MAXCRD+1)
) (
  input  logic                    agent_clk,
  input  logic                    agent_rst_b,
  input  logic                    pc_irdy,
  input  logic                    pc_eom,
  input  logic                    pc_parity,
  input  logic [INTERNALPLDBIT:0] pc_payload,
  input  logic                    np_irdy,
  input  logic                    np_eom,
  input  logic                    np_parity,
  input  logic [INTERNALPLDBIT:0] np_payload,
  output logic                    pc_trdy,
  output logic                    np_trdy,
  output logic                    pc_sel,
  output logic                    np_sel,
  output logic                    mst_put,
  output logic                    mst_np,
  output logic                    mst_eom,
  output logic                    mst_parity,
  output logic [INTERNALPLDBIT:0] mst_payload,
  input  logic                    mst_ready,
  input  logic                    pccup,
  input  logic                    npcup,
  output logic                    parity_err,
  output logic                    crd_ovf
);

  arb_state_t state, state_nxt;
  logic       last_grant;
  logic       pc_grant, np_grant;
  logic       elig_pc, elig_np;
  logic       pc_nz, np_nz, pc_ovf, np_ovf;
  logic [CRDW-1:0] pc_crd, np_crd;
  logic       egress_free;
  logic       pc_xfer, np_xfer, xfer;
  logic                    in_eom, in_parity;
  logic [INTERNALPLDBIT:0] in_payload;

  hqm_sbemst_crdcnt #(.MAXCRD(MAXCRD)) u_pc_crd (
    .agent_clk   (agent_clk),
    .agent_rst_b (agent_rst_b),
    .cup         (pccup),
    .consume     (pc_grant),
    .count       (pc_crd),
    .nonzero     (pc_nz),
    .ovf         (pc_ovf)
  );

  hqm_sbemst_crdcnt #(.MAXCRD(MAXCRD)) u_np_crd (
    .agent_clk   (agent_clk),
    .agent_rst_b (agent_rst_b),
    .cup         (npcup),
    .consume     (np_grant),
    .count       (np_crd),
    .nonzero     (np_nz),
    .ovf         (np_ovf)
  );

  assign crd_ovf = pc_ovf | np_ovf;

  // sel comes straight from the state flop so it is one cycle after the grant
  assign pc_sel      = (state == PC_MSG);
  assign np_sel      = (state == NP_MSG);
  assign egress_free = !mst_put || mst_ready;
  assign pc_trdy     = pc_sel && egress_free;
  assign np_trdy     = np_sel && egress_free;
  assign pc_xfer     = pc_irdy && pc_trdy;
  assign np_xfer     = np_irdy && np_trdy;
  assign xfer        = pc_xfer || np_xfer;

  assign elig_pc = pc_irdy && pc_nz;
  assign elig_np = np_irdy && np_nz;

  // Owning class drives the egress register input
  assign in_eom     = np_sel ? np_eom     : pc_eom;
  assign in_parity  = np_sel ? np_parity  : pc_parity;
  assign in_payload = np_sel ? np_payload : pc_payload;

  // Next-state and grant: arbitrate only in IDLE, release ownership on the eom flit
  always_comb begin
    state_nxt = state;
    pc_grant  = 1'b0;
    np_grant  = 1'b0;
    case (state)
      IDLE: begin
        if (elig_pc && (!elig_np || (last_grant == CLS_NP))) begin
          pc_grant  = 1'b1;
          state_nxt = PC_MSG;
        end else if (elig_np) begin
          np_grant  = 1'b1;
          state_nxt = NP_MSG;
        end
      end
      PC_MSG: if (pc_xfer && pc_eom) state_nxt = IDLE;
      NP_MSG: if (np_xfer && np_eom) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge agent_clk or negedge agent_rst_b) begin
    if (!agent_rst_b) state <= IDLE;
    else              state <= state_nxt;
  end

  // Round-robin memory; reset to NP so PC wins the first tie
  always_ff @(posedge agent_clk or negedge agent_rst_b) begin
    if (!agent_rst_b)  last_grant <= CLS_NP;
    else if (pc_grant) last_grant <= CLS_PC;
    else if (np_grant) last_grant <= CLS_NP;
  end

  // Egress register: load on transfer, drop valid once the fabric takes it
  always_ff @(posedge agent_clk or negedge agent_rst_b) begin
    if (!agent_rst_b) begin
      mst_put     <= 1'b0;
      mst_np      <= CLS_PC;
      mst_eom     <= 1'b0;
      mst_parity  <= 1'b0;
      mst_payload <= '0;
    end else if (xfer) begin
      mst_put     <= 1'b1;
      mst_np      <= np_xfer ? CLS_NP : CLS_PC;
      mst_eom     <= in_eom;
      mst_parity  <= in_parity;
      mst_payload <= in_payload;
    end else if (mst_ready) begin
      mst_put     <= 1'b0;
    end
  end

  // Sticky parity error on any accepted flit; the flit itself is forwarded as-is
  always_ff @(posedge agent_clk or negedge agent_rst_b) begin
    if (!agent_rst_b) begin
      parity_err <= 1'b0;
    end else if (xfer && (^{in_payload, in_eom, in_parity})) begin
      parity_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hqm_sbemst_arb.sv
// Directed bench for hqm_sbemst_arb: cycle tables plus hand-written corner sequences.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure exercised via mst_ready stalls mid-message.
module tb_hqm_sbemst_arb;

  logic        agent_clk = 1'b0;
  logic        agent_rst_b;
  logic        pc_irdy, pc_eom, pc_parity;
  logic [31:0] pc_payload;
  logic        np_irdy, np_eom, np_parity;
  logic [31:0] np_payload;
  logic        pc_trdy, np_trdy, pc_sel, np_sel;
  logic        mst_put, mst_np, mst_eom, mst_parity;
  logic [31:0] mst_payload;
  logic        mst_ready, pccup, npcup;
  logic        parity_err, crd_ovf;

  int tests = 0;
  int fails = 0;

  always #5 agent_clk = ~agent_clk;

  hqm_sbemst_arb dut (
    .agent_clk   (agent_clk),
    .agent_rst_b (agent_rst_b),
    .pc_irdy     (pc_irdy),
    .pc_eom      (pc_eom),
    .pc_parity   (pc_parity),
    .pc_payload  (pc_payload),
    .np_irdy     (np_irdy),
    .np_eom      (np_eom),
    .np_parity   (np_parity),
    .np_payload  (np_payload),
    .pc_trdy     (pc_trdy),
    .np_trdy     (np_trdy),
    .pc_sel      (pc_sel),
    .np_sel      (np_sel),
    .mst_put     (mst_put),
    .mst_np      (mst_np),
    .mst_eom     (mst_eom),
    .mst_parity  (mst_parity),
    .mst_payload (mst_payload),
    .mst_ready   (mst_ready),
    .pccup       (pccup),
    .npcup       (npcup),
    .parity_err  (parity_err),
    .crd_ovf     (crd_ovf)
  );

  typedef struct {
    logic        pccup, npcup;
    logic        pci, pce;
    logic [31:0] pcp;
    logic        npi, npe;
    logic [31:0] npp;
    logic        rdy;
    logic        e_pcsel, e_npsel, e_pctr, e_nptr, e_put, e_np, e_eom;
    logic [31:0] e_pld;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    pc_irdy = 0; pc_eom = 0; pc_parity = 0; pc_payload = '0;
    np_irdy = 0; np_eom = 0; np_parity = 0; np_payload = '0;
    mst_ready = 1; pccup = 0; npcup = 0;
  endtask

  // Applies reset; returns at posedge+1 ready to drive cycle 0
  task automatic do_reset();
    clr_in();
    @(negedge agent_clk);
    agent_rst_b = 0;
    @(negedge agent_clk);
    agent_rst_b = 1;
    @(posedge agent_clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge agent_clk); #1;
  endtask

  // Applies each vector for one cycle and checks the outputs seen in that cycle
  task automatic run_table(input string name);
    logic [63:0] act, exp;
    for (int i = 0; i < vq.size(); i++) begin
      pccup = vq[i].pccup; npcup = vq[i].npcup;
      pc_irdy = vq[i].pci; pc_eom = vq[i].pce; pc_payload = vq[i].pcp;
      pc_parity = ^{vq[i].pcp, vq[i].pce};
      np_irdy = vq[i].npi; np_eom = vq[i].npe; np_payload = vq[i].npp;
      np_parity = ^{vq[i].npp, vq[i].npe};
      mst_ready = vq[i].rdy;
      @(negedge agent_clk);
      act = {27'd0, pc_sel, np_sel, pc_trdy, np_trdy, mst_put, 34'd0};
      exp = {27'd0, vq[i].e_pcsel, vq[i].e_npsel, vq[i].e_pctr, vq[i].e_nptr, vq[i].e_put, 34'd0};
      if (vq[i].e_put) begin
        act[33:0] = {mst_np, mst_eom, mst_payload};
        exp[33:0] = {vq[i].e_np, vq[i].e_eom, vq[i].e_pld};
      end
      chk($sformatf("%s[%0d]", name, i), act, exp);
      next_cycle();
    end
    clr_in();
    vq.delete();
  endtask

  logic [31:0] f [4];
  logic [31:0] rx [$];
  int idx;
  logic pop;

  initial begin
    agent_rst_b = 1;
    clr_in();
    #2 agent_rst_b = 0;
    #10;
    chk("reset_outputs",
        {56'd0, pc_trdy, np_trdy, pc_sel, np_sel, mst_put, parity_err, crd_ovf, mst_np},
        64'd0);
    chk("reset_payload", {32'd0, mst_payload}, 64'd0);
    chk("reset_credits", {60'd0, dut.pc_crd[1:0], dut.np_crd[1:0]}, 64'd0);

    // Single 3-flit PC message, then credit exhausted
    do_reset();
    //           cup   pci pce pcp       npi npe npp rdy  psel nsel ptr ntr put np eom pld
    vq.push_back('{1,0, 0,0, 32'h00,    0,0, 32'h0, 1,  0,0,0,0, 0,0,0, 32'h00});
    vq.push_back('{0,0, 1,0, 32'h11,    0,0, 32'h0, 1,  0,0,0,0, 0,0,0, 32'h00});
    vq.push_back('{0,0, 1,0, 32'h11,    0,0, 32'h0, 1,  1,0,1,0, 0,0,0, 32'h00});
    vq.push_back('{0,0, 1,0, 32'h22,    0,0, 32'h0, 1,  1,0,1,0, 1,0,0, 32'h11});
    vq.push_back('{0,0, 1,1, 32'h33,    0,0, 32'h0, 1,  1,0,1,0, 1,0,0, 32'h22});
    vq.push_back('{0,0, 0,0, 32'h00,    0,0, 32'h0, 1,  0,0,0,0, 1,0,1, 32'h33});
    vq.push_back('{0,0, 1,1, 32'h44,    0,0, 32'h0, 1,  0,0,0,0, 0,0,0, 32'h00});
    vq.push_back('{0,0, 1,1, 32'h44,    0,0, 32'h0, 1,  0,0,0,0, 0,0,0, 32'h00});
    run_table("single_pc");
    @(negedge agent_clk);
    chk("single_pc_crd0", {62'd0, dut.pc_crd[1:0]}, 64'd0);
    chk("single_pc_noperr", {63'd0, parity_err}, 64'd0);
    next_cycle();

    // Contention: 2 credits each, alternating PC, NP, PC, NP with bubbles
    do_reset();
    vq.push_back('{1,1, 0,0, 32'h00, 0,0, 32'h00, 1,  0,0,0,0, 0,0,0, 32'h00});
    vq.push_back('{1,1, 0,0, 32'h00, 0,0, 32'h00, 1,  0,0,0,0, 0,0,0, 32'h00});
    vq.push_back('{0,0, 1,1, 32'hA1, 1,1, 32'hB1, 1,  0,0,0,0, 0,0,0, 32'h00});
    vq.push_back('{0,0, 1,1, 32'hA1, 1,1, 32'hB1, 1,  1,0,1,0, 0,0,0, 32'h00});
    vq.push_back('{0,0, 1,1, 32'hA2, 1,1, 32'hB1, 1,  0,0,0,0, 1,0,1, 32'hA1});
    vq.push_back('{0,0, 1,1, 32'hA2, 1,1, 32'hB1, 1,  0,1,0,1, 0,0,0, 32'h00});
    vq.push_back('{0,0, 1,1, 32'hA2, 1,1, 32'hB2, 1,  0,0,0,0, 1,1,1, 32'hB1});
    vq.push_back('{0,0, 1,1, 32'hA2, 1,1, 32'hB2, 1,  1,0,1,0, 0,0,0, 32'h00});
    vq.push_back('{0,0, 0,0, 32'h00, 1,1, 32'hB2, 1,  0,0,0,0, 1,0,1, 32'hA2});
    vq.push_back('{0,0, 0,0, 32'h00, 1,1, 32'hB2, 1,  0,1,0,1, 0,0,0, 32'h00});
    vq.push_back('{0,0, 0,0, 32'h00, 0,0, 32'h00, 1,  0,0,0,0, 1,1,1, 32'hB2});
    vq.push_back('{0,0, 0,0, 32'h00, 0,0, 32'h00, 1,  0,0,0,0, 0,0,0, 32'h00});
    run_table("contention");

    // Zero credit: NP waits 10 cycles, then one cup grants two cycles later
    do_reset();
    np_irdy = 1; np_eom = 1; np_payload = 32'h55; np_parity = ^{32'h55, 1'b1};
    for (int c = 0; c < 10; c++) begin
      @(negedge agent_clk);
      chk($sformatf("zero_crd_wait[%0d]", c), {62'd0, np_sel, mst_put}, 64'd0);
      next_cycle();
    end
    npcup = 1;
    @(negedge agent_clk);
    chk("zero_crd_cup_cycle", {63'd0, np_sel}, 64'd0);
    next_cycle();
    npcup = 0;
    @(negedge agent_clk);
    chk("zero_crd_cup_plus1", {63'd0, np_sel}, 64'd0);
    next_cycle();
    @(negedge agent_clk);
    chk("zero_crd_cup_plus2", {62'd0, np_sel, np_trdy}, 64'd3);
    next_cycle();
    np_irdy = 0;
    @(negedge agent_clk);
    chk("zero_crd_egress", {30'd0, mst_put, mst_np, mst_payload}, {30'd0, 2'b11, 32'h55});
    next_cycle();

    // Backpressure: 4-flit PC message, mst_ready low in cycles 4..7
    do_reset();
    f[0] = 32'hC0; f[1] = 32'hC1; f[2] = 32'hC2; f[3] = 32'hC3;
    idx = 0;
    rx.delete();
    for (int cyc = 0; cyc < 16; cyc++) begin
      pccup      = (cyc == 0);
      pc_irdy    = (cyc >= 1) && (idx < 4);
      pc_payload = (idx < 4) ? f[idx] : 32'h0;
      pc_eom     = (idx == 3);
      pc_parity  = ^{pc_payload, pc_eom};
      mst_ready  = !(cyc >= 4 && cyc <= 7);
      @(negedge agent_clk);
      if (!mst_ready) begin
        chk($sformatf("bp_trdy[%0d]", cyc), {63'd0, pc_trdy}, 64'd0);
        chk($sformatf("bp_hold[%0d]", cyc), {31'd0, mst_put, mst_payload}, {31'd0, 1'b1, 32'hC1});
      end
      pop = pc_irdy && pc_trdy;
      if (mst_put && mst_ready) rx.push_back(mst_payload);
      next_cycle();
      if (pop) idx++;
    end
    clr_in();
    chk("bp_rx_count", 64'(rx.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_rx[%0d]", i), {32'd0, (i < rx.size()) ? rx[i] : 32'hDEAD}, {32'd0, f[i]});

    // Credit edges: fill to MAXCRD, cup+grant same cycle, then overflow
    do_reset();
    for (int c = 0; c < 4; c++) begin
      pccup = 1;
      next_cycle();
    end
    pccup = 0;
    @(negedge agent_clk);
    chk("crd_full", {61'd0, dut.pc_crd, crd_ovf}, {61'd0, 3'd4, 1'b0});
    next_cycle();
    pccup = 1; pc_irdy = 1; pc_eom = 1; pc_payload = 32'h66; pc_parity = ^{32'h66, 1'b1};
    next_cycle();
    pccup = 0;
    @(negedge agent_clk);
    chk("crd_cup_and_grant", {60'd0, dut.pc_crd, crd_ovf, pc_sel}, {60'd0, 3'd4, 1'b0, 1'b1});
    next_cycle();
    pc_irdy = 0;
    pccup = 1;
    next_cycle();
    pccup = 0;
    @(negedge agent_clk);
    chk("crd_ovf", {61'd0, dut.pc_crd, crd_ovf}, {61'd0, 3'd4, 1'b1});
    next_cycle();

    // Bad parity flit is flagged and still forwarded
    do_reset();
    npcup = 1;
    next_cycle();
    npcup = 0; np_irdy = 1; np_eom = 1; np_payload = 32'h01; np_parity = 1'b1;
    next_cycle();
    @(negedge agent_clk);
    chk("par_before", {62'd0, parity_err, np_trdy}, 64'd1);
    next_cycle();
    np_irdy = 0;
    @(negedge agent_clk);
    chk("par_forward", {29'd0, parity_err, mst_put, mst_parity, mst_payload},
        {29'd0, 3'b111, 32'h01});
    next_cycle();

    // Reset asserted mid-message clears ownership, egress and credits
    do_reset();
    pccup = 1;
    next_cycle();
    next_cycle();
    pccup = 0; pc_irdy = 1; pc_eom = 0; pc_payload = 32'h77; pc_parity = ^{32'h77, 1'b0};
    next_cycle();
    next_cycle();
    next_cycle();
    #2 agent_rst_b = 0;
    #1;
    chk("rst_mid_msg", {59'd0, pc_sel, pc_trdy, mst_put, dut.pc_crd[1:0]}, 64'd0);
    @(negedge agent_clk);
    agent_rst_b = 1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge agent_clk);
      chk($sformatf("rst_after[%0d]", c), {62'd0, pc_sel, mst_put}, 64'd0);
    end
    clr_in();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
